// File: rtl/theta_pkg.sv
// theta_pkg: shared constants, state encoding and helpers for the theta-apply
// block (column-parity consumer of the permutation datapath).
//   LANE_W    : lane / parity word width
//   NUM_LANES : lanes per 5x5 state
//   NUM_COLS  : columns per state
//   state_t   : controller states IDLE, LOAD_PAR, CALC_D, STREAM, DONE
//   rotl1     : rotate a lane left by one bit
package theta_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int NUM_COLS  = 5;
    localparam int IDX_W     = 5;
    localparam int COL_W     = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_PAR = 3'd1,
        CALC_D   = 3'd2,
        STREAM   = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
        return {v[LANE_W-2:0], v[LANE_W-1]};
    endfunction

endpackage

// File: rtl/theta_lane_cnt.sv
// theta_lane_cnt: paired index / column counter. The index counts accepted
// items 0..LIMIT and saturates at LIMIT; the column counter wraps 4 -> 0 in
// step with it, so no division is ever needed to find the column.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   clr  : synchronous clear of both counters
//   en   : advance by one (ignored once the index reaches LIMIT)
//   idx  : item index
//   col  : column of the current item (idx mod 5)
//   term : index is on the last item (LIMIT-1)
//   full : all LIMIT items have been counted
module theta_lane_cnt
    import theta_pkg::*;
#(
    parameter int LIMIT = NUM_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic [COL_W-1:0] col,
    output logic             term,
    output logic             full
);

    logic [IDX_W-1:0] idx_r;
    logic [COL_W-1:0] col_r;
    logic             full_s;

    assign full_s = (idx_r == IDX_W'(LIMIT));

    // Index and column counters advance together on each enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_r <= {IDX_W{1'b0}};
            col_r <= {COL_W{1'b0}};
        end else if (clr) begin
            idx_r <= {IDX_W{1'b0}};
            col_r <= {COL_W{1'b0}};
        end else if (en && !full_s) begin
            idx_r <= idx_r + IDX_W'(1);
            col_r <= (col_r == COL_W'(NUM_COLS - 1)) ? {COL_W{1'b0}} : col_r + COL_W'(1);
        end else begin
            idx_r <= idx_r;
            col_r <= col_r;
        end
    end

    assign idx  = idx_r;
    assign col  = col_r;
    assign term = (idx_r == IDX_W'(LIMIT - 1));
    assign full = full_s;

endmodule

// File: rtl/theta_apply.sv
// theta_apply: loads five column parities C[0..4], forms the theta offsets
// D[x] = C[(x+4) mod 5] ^ rotl1(C[(x+1) mod 5]), then streams the 25 state
// lanes through with lane_out = A[i] ^ D[i mod 5] and valid/ready flow control.
// Optional feature macro: THETA_PAR_CHECK_EN (recomputes the column XOR of the
// streamed lanes and flags a mismatch against the loaded parities on par_err).
// Ports:
//   clk, rst               : clock, synchronous active-low reset
//   start                  : begin a frame (IDLE only)
//   par_in, par_valid      : column parity words C[0..4] in order (LOAD_PAR only)
//   lane_in, lane_valid    : state lanes A[0..24] in order
//   lane_ready             : lane accepted when lane_valid & lane_ready
//   lane_out, out_valid    : theta-applied lane, held under backpressure
//   out_ready              : downstream accept
//   busy                   : controller not in IDLE
//   done                   : one-cycle pulse after the last lane is consumed
//   par_err                : parity mismatch flag (0 unless the check is built)
module theta_apply
    import theta_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LANE_W-1:0] par_in,
    input  logic              par_valid,
    input  logic [LANE_W-1:0] lane_in,
    input  logic              lane_valid,
    output logic              lane_ready,
    output logic [LANE_W-1:0] lane_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              par_err
);

    state_t            state_r;
    state_t            state_nxt_s;

    logic [LANE_W-1:0] c_r [NUM_COLS];
    logic [LANE_W-1:0] d_r [NUM_COLS];
    logic [LANE_W-1:0] lane_out_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;

    logic              par_acc_s;
    logic              lane_ready_s;
    logic              lane_acc_s;
    logic              frame_end_s;

    logic [IDX_W-1:0]  p_idx_s;
    logic [COL_W-1:0]  p_col_s;
    logic              p_term_s;
    logic              p_full_s;
    logic [IDX_W-1:0]  l_idx_s;
    logic [COL_W-1:0]  l_col_s;
    logic              l_term_s;
    logic              l_full_s;
    logic              unused_s;

    assign par_acc_s    = (state_r == LOAD_PAR) && par_valid;
    // The !l_full_s term keeps a 26th lane from being swallowed while the
    // last output is still waiting downstream.
    assign lane_ready_s = (state_r == STREAM) && !l_full_s && (!out_valid_r || out_ready);
    assign lane_acc_s   = lane_ready_s && lane_valid;
    assign frame_end_s  = (state_r == STREAM) && out_valid_r && out_ready && l_full_s;

    // Parity word index p, cleared when a frame starts.
    theta_lane_cnt #(.LIMIT(NUM_COLS)) u_par_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_r == IDLE) && start),
        .en   (par_acc_s),
        .idx  (p_idx_s),
        .col  (p_col_s),
        .term (p_term_s),
        .full (p_full_s)
    );

    // Lane index i and column x, cleared in CALC_D just before streaming.
    theta_lane_cnt #(.LIMIT(NUM_LANES)) u_lane_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_r == CALC_D),
        .en   (lane_acc_s),
        .idx  (l_idx_s),
        .col  (l_col_s),
        .term (l_term_s),
        .full (l_full_s)
    );

    assign unused_s = ^{p_idx_s, p_full_s, l_idx_s, l_term_s};

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD_PAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_PAR: begin
                if (par_acc_s && p_term_s) begin
                    state_nxt_s = CALC_D;
                end else begin
                    state_nxt_s = LOAD_PAR;
                end
            end
            CALC_D: begin
                state_nxt_s = STREAM;
            end
            STREAM: begin
                if (frame_end_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Column parity store; written only while loading, kept until the next load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int x = 0; x < NUM_COLS; x++) begin
                c_r[x] <= {LANE_W{1'b0}};
            end
        end else if (par_acc_s) begin
            c_r[p_col_s] <= par_in;
        end else begin
            c_r <= c_r;
        end
    end

    // Theta offsets computed once per frame in CALC_D.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int x = 0; x < NUM_COLS; x++) begin
                d_r[x] <= {LANE_W{1'b0}};
            end
        end else if (state_r == CALC_D) begin
            for (int x = 0; x < NUM_COLS; x++) begin
                d_r[x] <= c_r[(x + NUM_COLS - 1) % NUM_COLS] ^ rotl1(c_r[(x + 1) % NUM_COLS]);
            end
        end else begin
            d_r <= d_r;
        end
    end

    // Output lane register: load on accept, drop valid when consumed, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_out_r  <= {LANE_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (state_r != STREAM) begin
            lane_out_r  <= lane_out_r;
            out_valid_r <= 1'b0;
        end else if (lane_acc_s) begin
            lane_out_r  <= lane_in ^ d_r[l_col_s];
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            lane_out_r  <= lane_out_r;
            out_valid_r <= 1'b0;
        end else begin
            lane_out_r  <= lane_out_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_nxt_s == DONE);
        end
    end

    assign lane_ready = lane_ready_s;
    assign lane_out   = lane_out_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

`ifdef THETA_PAR_CHECK_EN
    logic [LANE_W-1:0] k_r [NUM_COLS];
    logic              par_err_r;

    function automatic logic cols_mismatch(input logic [LANE_W-1:0] k [NUM_COLS],
                                           input logic [LANE_W-1:0] c [NUM_COLS]);
        logic diff;
        diff = 1'b0;
        for (int x = 0; x < NUM_COLS; x++) begin
            diff = diff | (|(k[x] ^ c[x]));
        end
        return diff;
    endfunction

    // Running XOR of accepted lanes per column, restarted each frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int x = 0; x < NUM_COLS; x++) begin
                k_r[x] <= {LANE_W{1'b0}};
            end
        end else if (state_r == CALC_D) begin
            for (int x = 0; x < NUM_COLS; x++) begin
                k_r[x] <= {LANE_W{1'b0}};
            end
        end else if (lane_acc_s) begin
            k_r[l_col_s] <= k_r[l_col_s] ^ lane_in;
        end else begin
            k_r <= k_r;
        end
    end

    // Mismatch verdict latched on entry to DONE, held until the next start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_err_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            par_err_r <= 1'b0;
        end else if (frame_end_s) begin
            par_err_r <= cols_mismatch(k_r, c_r);
        end else begin
            par_err_r <= par_err_r;
        end
    end

    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_theta_apply.sv
// Self-checking bench for theta_apply: a driver issues frames and pushes the
// expected lanes / parity verdicts into queues; a monitor pops and compares
// whenever the DUT hands a lane downstream or pulses done.
module tb_theta_apply;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] par_in;
    logic        par_valid;
    logic [63:0] lane_in;
    logic        lane_valid;
    logic        lane_ready;
    logic [63:0] lane_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        par_err;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int out_seen = 0;
    int ready_mode = 0;
    int hold_cnt = 0;

    logic [63:0] sb [$];
    bit          exp_err_q [$];

    always #5 clk = ~clk;

    theta_apply dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .par_in     (par_in),
        .par_valid  (par_valid),
        .lane_in    (lane_in),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .lane_out   (lane_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .par_err    (par_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rl1(input logic [63:0] v);
        return (v << 1) | (v >> 63);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: compare every downstream handshake and every done pulse.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_lane: got %h expected none", lane_out);
                end else begin
                    check("lane_out", lane_out, sb.pop_front());
                    out_seen++;
                end
            end else begin
                check("stall_lane_ready", 64'(lane_ready), 64'd0);
                if (sb.size() > 0) check("stall_hold", lane_out, sb[0]);
            end
        end
        if (rst && done) begin
            done_cnt++;
            if (exp_err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got 1 expected 0");
            end else begin
                check("par_err", 64'(par_err), 64'(exp_err_q.pop_front()));
            end
        end
    end

    // Downstream ready: always, random, or a 3-cycle stall on lane 7.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(3) != 0);
            2: begin
                if (out_seen == 7 && hold_cnt < 3) begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    task automatic run_frame(input logic [63:0] c [5], input logic [63:0] a [25],
                             input bit gaps, input int rst_at);
        logic [63:0] d [5];
        logic [63:0] k [5];
        bit          exp_err;
        int          prev_done;
        int          t;
        for (int x = 0; x < 5; x++) begin
            d[x] = c[(x + 4) % 5] ^ rl1(c[(x + 1) % 5]);
            k[x] = 64'd0;
        end
        for (int i = 0; i < 25; i++) k[i % 5] = k[i % 5] ^ a[i];
        exp_err = 1'b0;
`ifdef THETA_PAR_CHECK_EN
        for (int x = 0; x < 5; x++) if (k[x] != c[x]) exp_err = 1'b1;
`endif
        prev_done = done_cnt;
        out_seen  = 0;
        hold_cnt  = 0;

        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        for (int p = 0; p < 5; p++) begin
            while (gaps && $urandom_range(2) == 0) begin
                par_valid = 1'b0;
                @(posedge clk) #1;
            end
            par_valid = 1'b1;
            par_in    = c[p];
            @(posedge clk) #1;
        end
        par_valid = 1'b0;
        par_in    = rnd64();

        for (int i = 0; i < 25; i++) begin
            if (i == rst_at) begin
                lane_valid = 1'b0;
                rst = 1'b0;
                @(posedge clk) #1;
                rst = 1'b1;
                sb.delete();
                out_seen = 0;
                @(negedge clk);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_lane_ready", 64'(lane_ready), 64'd0);
                check("rst_lane_out", lane_out, 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_par_err", 64'(par_err), 64'd0);
                @(posedge clk) #1;
                return;
            end
            while (gaps && $urandom_range(3) == 0) begin
                lane_valid = 1'b0;
                @(posedge clk) #1;
            end
            lane_valid = 1'b1;
            lane_in    = a[i];
            t = 0;
            forever begin
                @(negedge clk);
                if (lane_ready) break;
                t++;
                if (t > 200) break;
            end
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL lane_accept_timeout: got none expected lane %0d", i);
                lane_valid = 1'b0;
                return;
            end
            sb.push_back(a[i] ^ d[i % 5]);
            @(posedge clk) #1;
        end
        lane_valid = 1'b0;
        lane_in    = rnd64();
        exp_err_q.push_back(exp_err);

        t = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            t++;
            if (t > 500) break;
        end
        if (t > 500) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got busy expected idle");
        end
        check("done_count", 64'(done_cnt), 64'(prev_done + 1));
        check("sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk) #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c [5];
        logic [63:0] a [25];
        int          bit_pos;

        rst = 1'b0; start = 1'b0; par_valid = 1'b0; lane_valid = 1'b0;
        par_in = 64'd0; lane_in = 64'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_lane_ready", 64'(lane_ready), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_par_err", 64'(par_err), 64'd0);
        check("reset_lane_out", lane_out, 64'd0);
        @(posedge clk) #1;
        rst = 1'b1;
        // Stray inputs in IDLE must not start anything.
        par_valid = 1'b1; lane_valid = 1'b1;
        @(posedge clk) #1;
        par_valid = 1'b0; lane_valid = 1'b0;
        @(negedge clk);
        check("idle_ignore_busy", 64'(busy), 64'd0);
        @(posedge clk) #1;

        // Zero parities, lanes A[i] = i pass straight through.
        ready_mode = 0;
        for (int x = 0; x < 5; x++) c[x] = 64'd0;
        for (int i = 0; i < 25; i++) a[i] = 64'(i);
        run_frame(c, a, 1'b0, -1);

        // Single parity bit in C[1].
        for (int i = 0; i < 25; i++) a[i] = 64'd0;
        c[1] = 64'd1;
        run_frame(c, a, 1'b0, -1);

        // Rotation wrap of the top bit.
        c[1] = 64'h8000000000000000;
        run_frame(c, a, 1'b0, -1);

        // Backpressure stall on lane 7.
        ready_mode = 2;
        for (int x = 0; x < 5; x++) c[x] = rnd64();
        for (int i = 0; i < 25; i++) a[i] = rnd64();
        run_frame(c, a, 1'b0, -1);
        check("bp_hold_cycles", 64'(hold_cnt), 64'd3);

        // Reset mid-stream at i = 12, then a clean frame.
        ready_mode = 0;
        run_frame(c, a, 1'b0, 12);
        ready_mode = 1;
        for (int i = 0; i < 25; i++) a[i] = rnd64();
        run_frame(c, a, 1'b1, -1);

        // Parities consistent with the lanes, then C[3] off by one bit.
        for (int x = 0; x < 5; x++) c[x] = 64'd0;
        for (int i = 0; i < 25; i++) c[i % 5] = c[i % 5] ^ a[i];
        run_frame(c, a, 1'b1, -1);
        bit_pos = int'($urandom_range(63));
        c[3] = c[3] ^ (64'd1 << bit_pos);
        run_frame(c, a, 1'b1, -1);

        // Random frames with random gaps and backpressure.
        for (int f = 0; f < 4; f++) begin
            for (int x = 0; x < 5; x++) c[x] = rnd64();
            for (int i = 0; i < 25; i++) a[i] = rnd64();
            run_frame(c, a, 1'b1, -1);
        end

        repeat (4) @(posedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        check("final_err_q_empty", 64'(exp_err_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
